// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 interrupt controller slice.
package sm83_pkg;

  localparam int unsigned SM83_WORD_SIZE = 8;
  localparam int unsigned SM83_ADR_WIDTH = 16;
  localparam int unsigned SM83_NUM_SRC   = 5;

  typedef logic [SM83_WORD_SIZE-1:0] word_t;
  typedef logic [SM83_ADR_WIDTH-1:0] adr_t;
  typedef logic [SM83_NUM_SRC-1:0]   irq_t;

  localparam adr_t SM83_ADR_IF = 16'hFF0F;
  localparam adr_t SM83_ADR_IE = 16'hFFFF;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_idx_e;

endpackage

// File: rtl/sm83_irq_edge.sv
// Rising-edge detector for peripheral request levels; SM83_IRQ_SYNC_EN adds a
// 2-flop synchronizer in front. History flops reset high so held levels are not edges.
module sm83_irq_edge #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_src,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] w_src;
  logic [N-1:0] r_src_q;

`ifdef SM83_IRQ_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = i_src;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_src_q <= '1;
    else       r_src_q <= w_src;
  end

  assign o_rise = w_src & ~r_src_q;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// sm83 interrupt responder: IF/IE registers, request edge capture, irq mask and
// IF/IE bus access. Optional input synchronizer via SM83_IRQ_SYNC_EN.
module sm83_irq_ctrl
  import sm83_pkg::*;
#(
  parameter int unsigned           WORD_SIZE = SM83_WORD_SIZE,
  parameter int unsigned           ADR_WIDTH = SM83_ADR_WIDTH,
  parameter int unsigned           NUM_SRC   = SM83_NUM_SRC,
  parameter logic [ADR_WIDTH-1:0]  ADR_IF    = SM83_ADR_IF,
  parameter logic [ADR_WIDTH-1:0]  ADR_IE    = SM83_ADR_IE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 dout_oe,
  input  logic                 p_rd,
  input  logic                 p_wr,
  input  logic [NUM_SRC-1:0]   irq_src,
  output logic [WORD_SIZE-1:0] irq,
  input  logic [WORD_SIZE-1:0] iack
);

  logic [NUM_SRC-1:0]   r_if;
  logic [WORD_SIZE-1:0] r_ie;
  logic                 r_wr_q;
  logic                 r_rd_q;
  logic                 r_armed;

  logic [NUM_SRC-1:0]   w_rise;
  logic                 w_hit_if;
  logic                 w_hit_ie;
  logic                 w_wr_edge;
  logic                 w_rd_edge;
  logic [WORD_SIZE-1:0] w_if_word;
  logic [WORD_SIZE-1:0] w_irq;
  logic                 w_unused;

  sm83_irq_edge #(.N(NUM_SRC)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_src  (irq_src),
    .o_rise (w_rise)
  );

  // r_armed holds off strobe edge detection on the first clock after reset so a
  // strobe still high at release only loads the history flops.
  assign w_hit_if  = (adr == ADR_IF);
  assign w_hit_ie  = (adr == ADR_IE);
  assign w_wr_edge = r_armed & p_wr & ~r_wr_q;
  assign w_rd_edge = r_armed & p_rd & ~r_rd_q;
  assign w_unused  = ^iack[WORD_SIZE-1:NUM_SRC];

  always_comb begin
    w_if_word              = '1;
    w_if_word[NUM_SRC-1:0] = r_if;
    w_irq                  = '0;
    w_irq[NUM_SRC-1:0]     = r_if & r_ie[NUM_SRC-1:0];
  end

  assign irq = w_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
      r_wr_q  <= 1'b0;
      r_rd_q  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_wr_q  <= p_wr;
      r_rd_q  <= p_rd;
    end
  end

  // Source edges are OR'd in last so they survive a coincident write-0 or iack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if <= '0;
      r_ie <= '0;
    end else begin
      r_if <= (((w_wr_edge && w_hit_if) ? din[NUM_SRC-1:0] : r_if)
               & ~iack[NUM_SRC-1:0]) | w_rise;
      if (w_wr_edge && w_hit_ie) r_ie <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      dout_oe <= 1'b0;
    end else if (w_rd_edge && (w_hit_if || w_hit_ie)) begin
      dout    <= w_hit_if ? w_if_word : r_ie;
      dout_oe <= 1'b1;
    end else if (!p_rd) begin
      dout_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed self-checking bench for sm83_irq_ctrl (default and SM83_IRQ_SYNC_EN builds).
module tb_sm83_irq_ctrl;

`ifdef SM83_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] adr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        p_rd = 1'b0;
  logic        p_wr = 1'b0;
  logic [4:0]  irq_src = '0;
  logic [7:0]  irq;
  logic [7:0]  iack = '0;

  int n_checks = 0;
  int n_errors = 0;

  sm83_irq_ctrl #(.WORD_SIZE(8), .ADR_WIDTH(16), .NUM_SRC(5),
                  .ADR_IF(16'hFF0F), .ADR_IE(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .adr(adr), .din(din), .dout(dout), .dout_oe(dout_oe),
    .p_rd(p_rd), .p_wr(p_wr), .irq_src(irq_src), .irq(irq), .iack(iack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    adr = a; din = d; p_wr = 1'b1;
    tick();
    p_wr = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    adr = a; p_rd = 1'b1;
    tick();
    chk({tag, "_oe"}, {7'd0, dout_oe}, 8'h01);
    chk({tag, "_dout"}, dout, exp);
    p_rd = 1'b0;
    tick();
    chk({tag, "_oe_off"}, {7'd0, dout_oe}, 8'h00);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_irq", irq, 8'h00);
    chk("rst_dout", dout, 8'h00);
    chk("rst_oe", {7'd0, dout_oe}, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // 1: single source edge, then acknowledge
    wr(16'hFFFF, 8'h01);
    irq_src = 5'h01;
    chk("t1_pre", irq, 8'h00);
    repeat (LAT) tick();
    chk("t1_irq", irq, 8'h01);
    iack = 8'h01;
    tick();
    iack = 8'h00;
    chk("t1_ack", irq, 8'h00);
    rd_chk("t1_if", 16'hFF0F, 8'hE0);
    irq_src = 5'h00;
    repeat (LAT) tick();

    // 2: register writes and reads, plus an address miss
    wr(16'hFFFF, 8'hFF);
    wr(16'hFF0F, 8'h1F);
    chk("t2_irq", irq, 8'h1F);
    rd_chk("t2_if", 16'hFF0F, 8'hFF);
    rd_chk("t2_ie", 16'hFFFF, 8'hFF);
    adr = 16'hFF00; p_rd = 1'b1;
    tick();
    chk("t2_miss_oe", {7'd0, dout_oe}, 8'h00);
    p_rd = 1'b0;
    tick();

    // 3: source edge coincident with iack and write-0 of IF
    irq_src = 5'h04;
    repeat (LAT - 1) tick();
    adr = 16'hFF0F; din = 8'h00; p_wr = 1'b1; iack = 8'h04;
    tick();
    p_wr = 1'b0; iack = 8'h00;
    tick();
    chk("t3_setwins", irq, 8'h04);
    wr(16'hFF0F, 8'h1F);
    iack = 8'hFF;
    tick();
    iack = 8'h00;
    chk("t3_multi_ack", irq, 8'h00);
    rd_chk("t3_if", 16'hFF0F, 8'hE0);

    // 5: long write strobe with changing data commits once
    adr = 16'hFF0F; din = 8'h01; p_wr = 1'b1;
    tick();
    din = 8'h02;
    tick(); tick(); tick();
    p_wr = 1'b0;
    tick();
    chk("t5_single", irq, 8'h01);

    // read and write in the same window return pre-write contents
    adr = 16'hFFFF; din = 8'h55; p_rd = 1'b1; p_wr = 1'b1;
    tick();
    chk("rw_old", dout, 8'hFF);
    p_rd = 1'b0; p_wr = 1'b0;
    tick();
    rd_chk("rw_new", 16'hFFFF, 8'h55);
    irq_src = 5'h00;
    repeat (LAT) tick();

    // 4: sources and write strobe held high across reset release
    irq_src = 5'h1F;
    adr = 16'hFF0F; din = 8'h1F; p_wr = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    p_wr = 1'b0;
    repeat (LAT + 1) tick();
    rd_chk("t4_if", 16'hFF0F, 8'hE0);
    wr(16'hFFFF, 8'hFF);
    chk("t4_irq0", irq, 8'h00);
    irq_src = 5'h17;
    repeat (LAT) tick();
    irq_src = 5'h1F;
    repeat (LAT) tick();
    chk("t4_reraise", irq, 8'h08);

    // 6: reset during an active read clears without a clock edge
    adr = 16'hFFFF; p_rd = 1'b1;
    tick();
    chk("t6_oe", {7'd0, dout_oe}, 8'h01);
    chk("t6_dout", dout, 8'hFF);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_oe", {7'd0, dout_oe}, 8'h00);
    chk("t6_rst_dout", dout, 8'h00);
    chk("t6_rst_irq", irq, 8'h00);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t6_held_rd", {7'd0, dout_oe}, 8'h00);
    p_rd = 1'b0;
    tick();
    rd_chk("t6_ie", 16'hFFFF, 8'h00);
    rd_chk("t6_if", 16'hFF0F, 8'hE0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
